// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sequencing stage and its register file.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int REG_AW = 2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_NOP = 3'd6;

    localparam logic [2:0] SEL_IDLE = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two combinational operand reads, one debug read,
// one synchronous write port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = mem[raddr1];
    assign rdata2   = mem[raddr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Two-state sequencer feeding a 4-bit ALU: latch operands on accept, drive the
// ALU for one EXEC cycle, then write back the result and sticky flags.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [2:0]               instr_op,
    input  logic [$clog2(NREGS)-1:0] instr_rd,
    input  logic [$clog2(NREGS)-1:0] instr_rs1,
    input  logic [$clog2(NREGS)-1:0] instr_rs2,
    input  logic [DATA_W-1:0]        instr_imm,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [2:0]               alu_sel,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic                     alu_carry,
    input  logic                     alu_zero,
    input  logic                     alu_overflow,
    output logic                     flag_c,
    output logic                     flag_z,
    output logic                     flag_v,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int AW = $clog2(NREGS);

    state_t            state, state_nxt;
    logic              accept;
    logic [2:0]        op_p1;
    logic [AW-1:0]     rd_p1;
    logic [DATA_W-1:0] opa_p1, opb_p1, imm_p1;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic              is_alu, is_ldi, wr_en;
    logic [DATA_W-1:0] wr_data;

    assign accept  = instr_valid && instr_ready;
    assign is_alu  = (op_p1 <= OP_XOR);
    assign is_ldi  = (op_p1 == OP_LDI);
    assign wr_en   = (state == ST_EXEC) && (is_alu || is_ldi);
    assign wr_data = is_ldi ? imm_p1 : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU inputs come only from the latched instruction, never from instr_*.
    always_comb begin
        instr_ready = (state == ST_IDLE);
        alu_a       = '0;
        alu_b       = '0;
        alu_sel     = SEL_IDLE;
        if (state == ST_EXEC && is_alu) begin
            alu_a   = opa_p1;
            alu_b   = opb_p1;
            alu_sel = op_p1;
        end
    end

    // Stage p1: instruction and operands captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p1  <= OP_NOP;
            rd_p1  <= '0;
            opa_p1 <= '0;
            opb_p1 <= '0;
            imm_p1 <= '0;
        end else if (accept) begin
            op_p1  <= instr_op;
            rd_p1  <= instr_rd;
            opa_p1 <= rs1_data;
            opb_p1 <= rs2_data;
            imm_p1 <= instr_imm;
        end
    end

    // Stage p2: writeback pulse, last-write record and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            flag_v   <= 1'b0;
        end else begin
            wb_valid <= wr_en;
            if (wr_en) begin
                wb_addr <= rd_p1;
                wb_data <= wr_data;
            end
            if (state == ST_EXEC && is_alu) begin
                flag_c <= alu_carry;
                flag_z <= alu_zero;
                flag_v <= alu_overflow;
            end
        end
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_en),
        .waddr    (rd_p1),
        .wdata    (wr_data),
        .raddr1   (instr_rs1),
        .rdata1   (rs1_data),
        .raddr2   (instr_rs2),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl with a behavioural 4-bit ALU attached to its ALU port.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2;
    logic [3:0] instr_imm;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_carry, alu_zero, alu_overflow;
    logic       flag_c, flag_z, flag_v;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [3:0] wb_data;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_imm    (instr_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .flag_v       (flag_v),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Downstream ALU: carry is carry-out on ADD and borrow on SUB; overflow is
    // flagged when equal-sign operands give a result of the other sign.
    always_comb begin
        logic [4:0] wide;
        wide         = 5'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_sel)
            3'd0: begin
                wide      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_carry = wide[4];
            end
            3'd1: begin
                wide      = {1'b0, alu_a} - {1'b0, alu_b};
                alu_carry = wide[4];
            end
            3'd2: wide = {1'b0, alu_a & alu_b};
            3'd3: wide = {1'b0, alu_a | alu_b};
            3'd4: wide = {1'b0, alu_a ^ alu_b};
            default: wide = 5'd0;
        endcase
        alu_result = wide[3:0];
        alu_zero   = (wide[3:0] == 4'd0);
        if (alu_sel <= 3'd1)
            alu_overflow = (alu_a[3] == alu_b[3]) && (wide[3] != alu_a[3]);
    end

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [3:0] imm;
        logic [3:0] exp_a, exp_b;
        logic [2:0] exp_sel;
        logic       exp_wb;
        logic [1:0] exp_addr;
        logic [3:0] exp_data;
        logic [2:0] exp_flags;  // {c, z, v}
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_dbg_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = a[1:0];
            #1;
            check($sformatf("%s dbg r%0d", tag, a), {28'd0, dbg_data}, 32'd0);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (instr_ready !== 1'b1) check({tag, " ready timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        wait_ready(v.name);
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = v.op;
        instr_rd    = v.rd;
        instr_rs1   = v.rs1;
        instr_rs2   = v.rs2;
        instr_imm   = v.imm;
        @(posedge clk);
        #1;
        check({v.name, " exec ready"}, {31'd0, instr_ready}, 32'd0);
        check({v.name, " exec alu_a"}, {28'd0, alu_a}, {28'd0, v.exp_a});
        check({v.name, " exec alu_b"}, {28'd0, alu_b}, {28'd0, v.exp_b});
        check({v.name, " exec alu_sel"}, {29'd0, alu_sel}, {29'd0, v.exp_sel});
        @(negedge clk);
        // Garbage during EXEC must not leak into the in-flight instruction.
        instr_valid = 1'b0;
        instr_op    = 3'd2;
        instr_rd    = ~v.rd;
        instr_rs1   = ~v.rs1;
        instr_rs2   = ~v.rs2;
        instr_imm   = ~v.imm;
        @(posedge clk);
        #1;
        check({v.name, " wb_valid"}, {31'd0, wb_valid}, {31'd0, v.exp_wb});
        check({v.name, " flags"}, {29'd0, flag_c, flag_z, flag_v}, {29'd0, v.exp_flags});
        if (v.exp_wb) begin
            check({v.name, " wb_addr"}, {30'd0, wb_addr}, {30'd0, v.exp_addr});
            check({v.name, " wb_data"}, {28'd0, wb_data}, {28'd0, v.exp_data});
            dbg_addr = v.exp_addr;
            #1;
            check({v.name, " dbg_data"}, {28'd0, dbg_data}, {28'd0, v.exp_data});
        end
    endtask

    initial begin
        vecs[0] = '{"LDI r1=9",    3'd5, 2'd1, 2'd0, 2'd0, 4'd9, 4'd0, 4'd0, 3'd7, 1'b1, 2'd1, 4'd9, 3'b000};
        vecs[1] = '{"LDI r2=7",    3'd5, 2'd2, 2'd0, 2'd0, 4'd7, 4'd0, 4'd0, 3'd7, 1'b1, 2'd2, 4'd7, 3'b000};
        vecs[2] = '{"ADD r3=r1+r2", 3'd0, 2'd3, 2'd1, 2'd2, 4'd0, 4'd9, 4'd7, 3'd0, 1'b1, 2'd3, 4'd0, 3'b110};
        vecs[3] = '{"SUB r0=r2-r1", 3'd1, 2'd0, 2'd2, 2'd1, 4'd0, 4'd7, 4'd9, 3'd1, 1'b1, 2'd0, 4'he, 3'b100};
        vecs[4] = '{"XOR r1=r1^r1", 3'd4, 2'd1, 2'd1, 2'd1, 4'd0, 4'd9, 4'd9, 3'd4, 1'b1, 2'd1, 4'd0, 3'b010};
        vecs[5] = '{"LDI r1=5",    3'd5, 2'd1, 2'd0, 2'd0, 4'd5, 4'd0, 4'd0, 3'd7, 1'b1, 2'd1, 4'd5, 3'b010};

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = 3'd6;
        instr_rd    = 2'd0;
        instr_rs1   = 2'd0;
        instr_rs2   = 2'd0;
        instr_imm   = 4'd0;
        dbg_addr    = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset ready", {31'd0, instr_ready}, 32'd1);
        check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        check("reset flags", {29'd0, flag_c, flag_z, flag_v}, 32'd0);
        check("reset alu_sel", {29'd0, alu_sel}, 32'd7);
        check("reset alu_a", {28'd0, alu_a}, 32'd0);
        check_dbg_zero("reset");

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Valid held high: ADD r3=r1+r2 (5+7), NOP, OR r0=r1|r2 issue 2 cycles apart.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op = 3'd0; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2; instr_imm = 4'd0;
        @(posedge clk);
        #1;
        check("b2b add exec ready", {31'd0, instr_ready}, 32'd0);
        check("b2b add alu_a", {28'd0, alu_a}, 32'd5);
        check("b2b add alu_b", {28'd0, alu_b}, 32'd7);
        @(negedge clk);
        instr_op = 3'd6; instr_rd = 2'd0; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
        @(posedge clk);
        #1;
        check("b2b add alu_sel held", {29'd0, alu_sel}, 32'd7);
        check("b2b add wb_valid", {31'd0, wb_valid}, 32'd1);
        check("b2b add wb_data", {28'd0, wb_data}, 32'hc);
        check("b2b add flags", {29'd0, flag_c, flag_z, flag_v}, 32'b001);
        check("b2b idle ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("b2b nop exec ready", {31'd0, instr_ready}, 32'd0);
        check("b2b nop alu_sel", {29'd0, alu_sel}, 32'd7);
        check("b2b nop wb_valid low", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        instr_op = 3'd3; instr_rd = 2'd0; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
        @(posedge clk);
        #1;
        check("b2b nop no wb", {31'd0, wb_valid}, 32'd0);
        check("b2b nop flags kept", {29'd0, flag_c, flag_z, flag_v}, 32'b001);
        check("b2b nop wb_data held", {28'd0, wb_data}, 32'hc);
        check("b2b after nop ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("b2b or exec ready", {31'd0, instr_ready}, 32'd0);
        check("b2b or alu_sel", {29'd0, alu_sel}, 32'd3);
        check("b2b or alu_a", {28'd0, alu_a}, 32'd5);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b or wb_valid", {31'd0, wb_valid}, 32'd1);
        check("b2b or wb_addr", {30'd0, wb_addr}, 32'd0);
        check("b2b or wb_data", {28'd0, wb_data}, 32'd7);
        check("b2b or flags", {29'd0, flag_c, flag_z, flag_v}, 32'b000);

        // Reset asserted while ADD r2=r1+r1 is in EXEC.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op = 3'd0; instr_rd = 2'd2; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
        @(posedge clk);
        #1;
        check("rst-exec alu_sel", {29'd0, alu_sel}, 32'd0);
        check("rst-exec alu_a", {28'd0, alu_a}, 32'd5);
        instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst-exec ready", {31'd0, instr_ready}, 32'd1);
        check("rst-exec alu_sel idle", {29'd0, alu_sel}, 32'd7);
        check("rst-exec wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst-exec flags", {29'd0, flag_c, flag_z, flag_v}, 32'd0);
        check("rst-exec wb_data", {28'd0, wb_data}, 32'd0);
        check_dbg_zero("rst-exec");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-rst wb_valid", {31'd0, wb_valid}, 32'd0);
        check("post-rst ready", {31'd0, instr_ready}, 32'd1);
        check("post-rst alu_sel", {29'd0, alu_sel}, 32'd7);
        check_dbg_zero("post-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
